// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-fetch request bus between the PC stage and instruction memory.
interface pc_fetch_ctrl_if;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;

  modport master (output fetch_valid, output fetch_pc, input fetch_ready);
  modport slave  (input fetch_valid, input fetch_pc, output fetch_ready);
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC / next-PC stage: holds fetch PC, drives fetch handshake, redirects and flushes on taken control flow.
// Optional MISALIGN_TRAP_EN: traps (and holds until reset) on a take target with bit[1] set.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  pc_fetch_ctrl_if.master        fetch_bus,
  input  logic                   ex_valid,
  input  logic                   ex_is_branch,
  input  logic                   ex_is_jal,
  input  logic                   ex_is_jalr,
  input  logic                   brnch_taken,
  input  logic [31:0]            ex_pc,
  input  logic [31:0]            ex_imm,
  input  logic [31:0]            ex_rs1,
  output logic [31:0]            link_addr,
  output logic                   redirect,
`ifdef MISALIGN_TRAP_EN
  output logic                   misalign,
`endif
  output logic                   flush
);

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH, S_TRAP} state_e;
`else
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_e;
`endif

  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        redirect_q, redirect_d;
  logic        flush_q, flush_d;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_q, misalign_d;
`endif

  logic        take;
  logic [31:0] target;

  assign take   = ex_valid & (ex_is_jalr | ex_is_jal | (ex_is_branch & brnch_taken));
  assign target = ex_is_jalr ? ((ex_rs1 + ex_imm) & ~32'h1) : (ex_pc + ex_imm);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    redirect_d = 1'b0;
    flush_d    = 1'b0;
`ifdef MISALIGN_TRAP_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN, S_FLUSH: begin
        if (take) begin
`ifdef MISALIGN_TRAP_EN
          if (target[1]) begin
            pc_d       = target;
            state_d    = S_TRAP;
            flush_d    = 1'b1;
            misalign_d = 1'b1;
          end else begin
`endif
            pc_d       = {target[31:2], 2'b00};
            redirect_d = 1'b1;
            state_d    = S_FLUSH;
            cnt_d      = FLUSH_INIT;
            flush_d    = 1'b1;
`ifdef MISALIGN_TRAP_EN
          end
`endif
        end else if (state_q == S_FLUSH) begin
          // flush_q mirrors the post-decrement count so flush drops with the return to RUN
          cnt_d   = cnt_q - 2'd1;
          flush_d = (cnt_d != 2'd0);
          if (cnt_d == 2'd0) state_d = S_RUN;
        end else if (!stall && fetch_bus.fetch_ready) begin
          pc_d = pc_q + 32'd4;
        end
      end
`ifdef MISALIGN_TRAP_EN
      S_TRAP: flush_d = 1'b1;
`endif
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      cnt_q      <= '0;
      redirect_q <= 1'b0;
      flush_q    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      redirect_q <= redirect_d;
      flush_q    <= flush_d;
`ifdef MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign fetch_bus.fetch_valid = (state_q == S_RUN) & ~stall;
  assign fetch_bus.fetch_pc    = pc_q;
  assign link_addr             = ex_pc + 32'd4;
  assign redirect              = redirect_q;
  assign flush                 = flush_q;
`ifdef MISALIGN_TRAP_EN
  assign misalign              = misalign_q;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed literal checks plus randomized run against a rule-level model.
module tb_pc_fetch_ctrl;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          FC     = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, brnch_taken;
  logic [31:0] ex_pc, ex_imm, ex_rs1, link_addr;
  logic        redirect, flush;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;
`endif

  pc_fetch_ctrl_if bus();

  pc_fetch_ctrl #(.RESET_PC(RST_PC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .fetch_bus(bus.master),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal),
    .ex_is_jalr(ex_is_jalr), .brnch_taken(brnch_taken), .ex_pc(ex_pc),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .link_addr(link_addr), .redirect(redirect),
`ifdef MISALIGN_TRAP_EN
    .misalign(misalign),
`endif
    .flush(flush)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic clear_ex;
    ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0; brnch_taken = 0;
    ex_pc = '0; ex_imm = '0; ex_rs1 = '0;
  endtask

  task automatic do_jal(input logic [31:0] pc, input logic [31:0] imm);
    clear_ex;
    ex_valid = 1; ex_is_jal = 1; ex_pc = pc; ex_imm = imm;
  endtask

  // Rule-level model: remaining flush cycles, boot cycle flag, trap flag and the PC.
  bit          m_known = 0, m_boot = 0, m_redirect = 0, m_trap = 0;
  int          m_flush = 0;
  logic [31:0] m_pc = '0;

  always @(negedge clk) begin
    logic        take_m;
    logic [31:0] tgt;
    if (m_known) begin
      check("fetch_valid", 32'(bus.fetch_valid),
            32'(!m_boot && m_flush == 0 && !m_trap && !stall));
      check("fetch_pc", bus.fetch_pc, m_pc);
      check("redirect", 32'(redirect), 32'(m_redirect));
      check("flush", 32'(flush), 32'(m_flush > 0 || m_trap));
      check("link_addr", link_addr, ex_pc + 32'd4);
`ifdef MISALIGN_TRAP_EN
      check("misalign", 32'(misalign), 32'(m_trap));
`endif
    end
    take_m = ex_valid && (ex_is_jalr || ex_is_jal || (ex_is_branch && brnch_taken));
    tgt    = ex_is_jalr ? ((ex_rs1 + ex_imm) & 32'hFFFF_FFFE) : (ex_pc + ex_imm);
    if (!rst_n) begin
      m_known = 1; m_pc = RST_PC; m_boot = 1; m_flush = 0; m_redirect = 0; m_trap = 0;
    end else if (m_known) begin
      m_redirect = 0;
      if (m_boot) m_boot = 0;
      else if (m_trap) begin end
      else if (take_m) begin
`ifdef MISALIGN_TRAP_EN
        if (tgt[1]) begin m_trap = 1; m_pc = tgt; m_flush = 0; end
        else begin m_pc = tgt & 32'hFFFF_FFFC; m_flush = FC; m_redirect = 1; end
`else
        m_pc = tgt & 32'hFFFF_FFFC; m_flush = FC; m_redirect = 1;
`endif
      end else if (m_flush > 0) m_flush--;
      else if (!stall && bus.fetch_ready) m_pc = m_pc + 32'd4;
    end
  end

  initial begin
    rst_n = 0; stall = 0; bus.fetch_ready = 1; clear_ex;
    tick; tick;
    check("rst_pc", bus.fetch_pc, 32'h0);
    check("rst_redirect", 32'(redirect), 32'h0);
    check("rst_flush", 32'(flush), 32'h0);
    check("rst_valid", 32'(bus.fetch_valid), 32'h0);
    rst_n = 1; #1;
    check("boot_valid", 32'(bus.fetch_valid), 32'h0);
    tick; check("run_pc0", bus.fetch_pc, 32'h0); check("run_valid", 32'(bus.fetch_valid), 32'h1);
    tick; check("run_pc4", bus.fetch_pc, 32'h4);
    tick; check("run_pc8", bus.fetch_pc, 32'h8);
    bus.fetch_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick; check("hold_pc", bus.fetch_pc, 32'h8); check("hold_valid", 32'(bus.fetch_valid), 32'h1);
    end
    bus.fetch_ready = 1;
    tick; check("resume_pc", bus.fetch_pc, 32'hC);

    clear_ex; ex_valid = 1; ex_is_branch = 1; brnch_taken = 1; ex_pc = 32'h100; ex_imm = 32'hFFFF_FFF0;
    tick;
    check("br_pc", bus.fetch_pc, 32'hF0); check("br_redirect", 32'(redirect), 32'h1);
    check("br_flush", 32'(flush), 32'h1); check("br_valid", 32'(bus.fetch_valid), 32'h0);
    clear_ex;
    tick; check("br_redirect_off", 32'(redirect), 32'h0); check("br_flush_off", 32'(flush), 32'h0);
    check("br_fetch0", bus.fetch_pc, 32'hF0); check("br_fetch0_valid", 32'(bus.fetch_valid), 32'h1);
    tick; check("br_fetch1", bus.fetch_pc, 32'hF4);

    clear_ex; ex_valid = 1; ex_is_jalr = 1; ex_rs1 = 32'h2001; ex_imm = 32'h4; ex_pc = 32'h40;
    #1; check("jalr_link", link_addr, 32'h44);
    tick; check("jalr_pc", bus.fetch_pc, 32'h2004);
    clear_ex; tick;
    do_jal(32'hFFFF_FFFC, 32'h8);
    tick; check("jal_wrap_pc", bus.fetch_pc, 32'h4);
    clear_ex; tick;

    do_jal(32'h10, 32'h10);
    tick; clear_ex; tick; check("pre_stall_pc", bus.fetch_pc, 32'h20);
    stall = 1; ex_valid = 1; ex_is_branch = 1; brnch_taken = 0; ex_pc = 32'h18;
    for (int i = 0; i < 2; i++) begin
      tick;
      check("nt_pc", bus.fetch_pc, 32'h20); check("nt_redirect", 32'(redirect), 32'h0);
      check("nt_flush", 32'(flush), 32'h0); check("nt_valid", 32'(bus.fetch_valid), 32'h0);
    end
    stall = 0; clear_ex; #1;
    check("unstall_valid", 32'(bus.fetch_valid), 32'h1);
    tick; check("unstall_pc", bus.fetch_pc, 32'h24);

    do_jal(32'h0, 32'h80);
    tick; check("pre_rst_flush", 32'(flush), 32'h1);
    rst_n = 0; clear_ex;
    tick; check("rstflush_pc", bus.fetch_pc, RST_PC); check("rstflush_flush", 32'(flush), 32'h0);
    rst_n = 1; tick;

    do_jal(32'h10, 32'h6);
    tick;
`ifdef MISALIGN_TRAP_EN
    check("trap_pc", bus.fetch_pc, 32'h16); check("trap_misalign", 32'(misalign), 32'h1);
    check("trap_redirect", 32'(redirect), 32'h0);
    clear_ex; tick; tick;
    check("trap_hold_pc", bus.fetch_pc, 32'h16); check("trap_valid", 32'(bus.fetch_valid), 32'h0);
    rst_n = 0; tick; check("trap_rst_misalign", 32'(misalign), 32'h0);
    rst_n = 1;
`else
    check("mis_pc", bus.fetch_pc, 32'h14); check("mis_redirect", 32'(redirect), 32'h1);
`endif
    clear_ex; tick;

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst_n           = ($urandom_range(0, 99) != 0);
      stall           = ($urandom_range(0, 3) == 0);
      bus.fetch_ready = ($urandom_range(0, 3) != 0);
      ex_valid        = ($urandom_range(0, 2) == 0);
      ex_is_branch    = $urandom_range(0, 1) == 1;
      ex_is_jal       = $urandom_range(0, 3) == 0;
      ex_is_jalr      = $urandom_range(0, 3) == 0;
      brnch_taken     = $urandom_range(0, 1) == 1;
      ex_pc           = $urandom;
      ex_imm          = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 64));
      ex_rs1          = $urandom;
    end
    @(posedge clk); #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Program-counter and next-PC stage of the RV32I core. Consumes the branch comparator's taken flag plus execute-stage jump/branch info, and computes redirect targets. Holds the fetch PC and drives the instruction-memory request handshake. Issues the flush pulse that squashes wrong-path instructions.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
FLUSH_CYCLES, 1, cycles flush stays high after a redirect (legal range 1..3)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
stall  input  1  hazard stall; freezes PC, suppresses fetch request
fetch_valid  output  1  fetch request valid
fetch_ready  input  1  instruction memory accepts request
fetch_pc  output  32  fetch address (registered)
ex_valid  input  1  execute-stage instruction is valid
ex_is_branch  input  1  conditional branch in execute
ex_is_jal  input  1  JAL in execute
ex_is_jalr  input  1  JALR in execute
brnch_taken  input  1  branch comparator result
ex_pc  input  32  PC of execute-stage instruction
ex_imm  input  32  sign-extended immediate
ex_rs1  input  32  rs1 value (JALR base)
link_addr  output  32  ex_pc+4, combinational, for rd writeback
redirect  output  1  one-cycle pulse, fetch_pc reloaded this cycle
flush  output  1  squash younger pipeline stages

Behaviour:
- One clock; reset is synchronous and active-low. rst_n low at a rising edge overrides all other inputs, including mid-flush or mid-handshake.
- Reset values: fetch_pc=RESET_PC, redirect=0, flush=0, state=BOOT, flush counter=0. fetch_valid=0.
- States: BOOT, RUN, FLUSH.
- BOOT lasts exactly one cycle after rst_n goes high, then moves to RUN. The first request is at RESET_PC.
- fetch_valid = (state==RUN) & ~stall. Combinational from registered state and stall.
- take = ex_valid & (ex_is_jalr | ex_is_jal | (ex_is_branch & brnch_taken)).
- Target selection when several is_* flags are set: jalr > jal > branch.
  - jalr target: (ex_rs1+ex_imm) & ~32'h1.
  - jal and branch target: ex_pc+ex_imm.
  - All additions are modulo 2^32; wrap-around is silent.
- Priority at each edge: reset > take > stall > fetch handshake.
- take (in RUN or FLUSH):
  - Next cycle: fetch_pc=target with bits[1:0] forced to 00, redirect=1, state=FLUSH, counter=FLUSH_CYCLES.
  - Any handshake in the take cycle is discarded; the PC does not advance.
- FLUSH:
  - flush=1 while counter!=0; counter decrements each cycle.
  - Transition to RUN when the counter reaches 0. flush is high for exactly FLUSH_CYCLES cycles, starting the cycle after take.
  - take during FLUSH reloads fetch_pc and restarts the counter.
- RUN with ~take & ~stall & fetch_ready: fetch_pc <= fetch_pc+4. 0xFFFF_FFFC wraps to 0x0.
- RUN with stall or ~fetch_ready: fetch_pc holds. fetch_pc changes only on handshake, redirect or reset.
- redirect is high for one cycle only; it is never high two consecutive cycles unless take repeats.
- Branch not taken (ex_is_branch & ~brnch_taken): no effect on PC or state.

Optional Feature:
MISALIGN_TRAP_EN
- Without the macro: target bits[1:0] are silently cleared, as above. Port misalign does not exist.
- With the macro:
  - Adds output port misalign (1 bit) and state TRAP.
  - If a take target has bit[1]=1: fetch_pc=unmasked target (faulting address), redirect=0, flush=1, state=TRAP, misalign=1.
  - In TRAP: fetch_valid=0, flush=1, misalign=1. Held until reset.
  - Reset clears misalign.

Test Plan:
1. Release reset, fetch_ready=1, no take -> cycle after release fetch_valid=0. Then fetch_pc=0x0,0x4,0x8,0xC on consecutive cycles.
2. fetch_ready=0 for 3 cycles at fetch_pc=0x8 -> fetch_pc holds 0x8 and fetch_valid stays 1. Advances to 0xC the cycle after fetch_ready=1.
3. Taken branch, ex_pc=0x100, ex_imm=0xFFFF_FFF0, brnch_taken=1:
   - Next cycle fetch_pc=0xF0, redirect=1 for one cycle, flush=1 for one cycle (FLUSH_CYCLES=1), fetch_valid=0.
   - Then fetches 0xF0, 0xF4.
4. JALR with ex_rs1=0x2001, ex_imm=0x4, ex_pc=0x40 -> fetch_pc=0x2004, link_addr=0x44. Also: JAL with ex_pc=0xFFFF_FFFC, ex_imm=0x8 -> fetch_pc=0x4.
5. Branch not taken with stall=1 for 2 cycles at fetch_pc=0x20 -> redirect=0, flush=0, fetch_valid=0, fetch_pc=0x20. Resumes at 0x24 after the stall drops. Also: rst_n=0 during FLUSH -> next cycle fetch_pc=RESET_PC, flush=0.
6. JAL with ex_pc=0x10, ex_imm=0x6:
   - With MISALIGN_TRAP_EN: fetch_pc=0x16, misalign=1, fetch_valid=0 until rst_n=0.
   - Without MISALIGN_TRAP_EN: fetch_pc=0x14, redirect=1.
